ram_lookup: RTL and testbench
=============================

Name: ram_lookup

Overview:
- Read-side consumer of the two-RAM name/value store: mem0 holds 64-bit right-justified ASCII keys and mem1 holds the 8-bit values at the same addresses.
- Accepts a key lookup request and scans mem0 two entries per cycle, using both read ports on even/odd address pairs.
- On a match, reads mem1 at the matched address and returns hit, value and address through a valid/ready response channel.
- Sits directly downstream of the ram instances, which are driven through their r1/r2 ports.

Parameters:
ADDRWIDTH, 3, RAM address width; table depth 2**ADDRWIDTH
KEY_W, 64, key width (MAX_STRING_SZ*BYTE_SZ)
VAL_W, 8, value width (BYTE_SZ)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous active-high reset
req_valid  in  1  lookup request valid
req_ready  out  1  block can accept a request (high only in IDLE)
req_key  in  KEY_W  key to find
req_count  in  ADDRWIDTH+1  number of valid entries, addresses 0..req_count-1; sampled at accept
resp_valid  out  1  response valid
resp_ready  in  1  response consumed
resp_hit  out  1  1 = key found
resp_val  out  VAL_W  mem1 value on hit, 0 on miss
resp_addr  out  ADDRWIDTH  matched address on hit, 0 on miss
key_en_r1_n  out  1  mem0 read port 1 enable, active-low (even address)
key_addr_r1  out  ADDRWIDTH  mem0 read port 1 address
key_data_r1  in  KEY_W  mem0 read port 1 data
key_en_r2_n  out  1  mem0 read port 2 enable, active-low (odd address)
key_addr_r2  out  ADDRWIDTH  mem0 read port 2 address
key_data_r2  in  KEY_W  mem0 read port 2 data
val_en_r_n  out  1  mem1 read enable, active-low
val_addr_r  out  ADDRWIDTH  mem1 read address
val_data_r  in  VAL_W  mem1 read data

Behaviour:
- RAM read timing: data is valid on the cycle after the enable (low) and address are presented.
- Reset (async, rst=1):
  - State goes to IDLE; req_ready=1.
  - resp_valid, resp_hit, resp_val and resp_addr are 0.
  - All *_en_n outputs are 1 and all addresses are 0.
  - A reset mid-scan or mid-response abandons the lookup; no response is produced.
- FSM states: IDLE, SCAN, VAL, RESP.
- IDLE:
  - On req_valid and req_ready in cycle T, register the key and count.
  - If count is 0, go to RESP with a miss; resp_valid is high in T+1.
  - Otherwise go to SCAN with pair index p=0.
- SCAN, each cycle:
  - Compare the data returned from the previous issue.
  - If neither entry matches and more pairs remain, issue the next pair: port1 address 2p, port2 address 2p+1.
  - Port2 enable stays high when 2p+1 is greater than or equal to count; an unissued address is never compared.
  - The first issue occurs in T+1, with no compare that cycle.
- Match:
  - Full KEY_W equality.
  - If both entries in a pair match, the lower (even) address wins.
  - On a match, stop issuing, assert val_en_r_n=0 with val_addr_r set to the matched address, and go to VAL.
- VAL: capture val_data_r into resp_val and set resp_hit=1 and resp_addr; go to RESP.
- Miss: when the last pair has been compared with no match, go to RESP with hit=0, val=0, addr=0.
- Latency from accept in T:
  - Hit in pair k: resp_valid in T+4+k.
  - Miss: resp_valid in T+3+ceil(count/2).
- RESP:
  - resp_valid=1; the response outputs are held stable while resp_ready=0.
  - On resp_ready, go to IDLE; the next accept is possible no earlier than the following cycle.
- Maximum count is 2**ADDRWIDTH. Pair addresses never wrap; scanning ends at the last pair.

Optional Feature:
- Macro: RAM_LOOKUP_STATS_EN.
- Defined:
  - Adds outputs hit_cnt[15:0] and miss_cnt[15:0].
  - Each counter increments by one on every response handshake of its kind and saturates at 16'hFFFF.
  - Both counters reset to 0 on rst.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package ram_lookup_pkg contains:
  - BYTE_SZ=8 and MAX_STRING_SZ=8
  - typedef char_t as logic[BYTE_SZ*MAX_STRING_SZ-1:0]
  - the state enum lookup_state_t {IDLE, SCAN, VAL, RESP}
- Sub-module: one natural sub-module, ram_lookup_pair_cmp.
  - Combinational compare of two entries against the key, with per-port valid qualifiers.
  - Outputs: hit, and sel (0=even, 1=odd) with the even address taking priority.
- Remaining FSM and datapath stay in ram_lookup.

Test Plan:
1. Table {0:"Nesrine"/FF, 1:"Sridhar"/AA, 2:"Yong"/BB, 3:"Rupkatha"/EE, 4:"Aart"/CC}, count=5, key "Nesrine" accepted at T -> resp_valid at T+4, hit=1, val=FF, addr=0.
2. Same table, key "Rupkatha" -> T+5, hit=1, val=EE, addr=3. Key "Aart" -> T+6, hit=1, val=CC, addr=4; port2 enable never asserted for address 5.
3. Key "Bob", count=5 -> T+6, hit=0, val=00, addr=0. Same key with count=0 -> T+1 miss with no RAM enable asserted.
4. Duplicate key "Yong" written at addresses 2 and 3 -> hit at addr=2, val=BB. With "Aart" at address 4 and count=4 -> miss.
5. resp_ready held low for 5 cycles -> resp_* stable and req_ready=0 throughout. Then release -> IDLE; a second request is accepted the next cycle.
6. rst pulsed during SCAN -> all *_en_n=1 and resp_valid=0 immediately, no response emitted. With RAM_LOOKUP_STATS_EN, after 3 hits and 1 miss -> hit_cnt=3, miss_cnt=1; reset -> both 0.

Source files
------------

// File: rtl/ram_lookup_pkg.sv
// Shared types for the name/value store lookup: key character width and FSM encoding.
package ram_lookup_pkg;
  localparam int BYTE_SZ       = 8;
  localparam int MAX_STRING_SZ = 8;

  typedef logic [BYTE_SZ*MAX_STRING_SZ-1:0] char_t;

  typedef enum logic [1:0] {IDLE, SCAN, VAL, RESP} lookup_state_t;
endpackage

// File: rtl/ram_lookup_pair_cmp.sv
// Compares an even/odd pair of mem0 entries against the key; even entry wins on a double match.
module ram_lookup_pair_cmp #(
  parameter int KEY_W = 64
) (
  input  logic [KEY_W-1:0] key_i,
  input  logic [KEY_W-1:0] d0_i,
  input  logic [KEY_W-1:0] d1_i,
  input  logic             v0_i,
  input  logic             v1_i,
  output logic             hit_o,
  output logic             sel_o
);
  logic m0, m1;

  assign m0    = v0_i && (d0_i == key_i);
  assign m1    = v1_i && (d1_i == key_i);
  assign hit_o = m0 || m1;
  assign sel_o = !m0 && m1;
endmodule

// File: rtl/ram_lookup.sv
// Key lookup over the two-RAM name/value store, scanning mem0 two entries per cycle.
// Optional RAM_LOOKUP_STATS_EN adds saturating hit/miss response counters.
module ram_lookup
  import ram_lookup_pkg::*;
#(
  parameter int ADDRWIDTH = 3,
  parameter int KEY_W     = BYTE_SZ*MAX_STRING_SZ,
  parameter int VAL_W     = BYTE_SZ
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [KEY_W-1:0]     req_key,
  input  logic [ADDRWIDTH:0]   req_count,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_hit,
  output logic [VAL_W-1:0]     resp_val,
  output logic [ADDRWIDTH-1:0] resp_addr,
  output logic                 key_en_r1_n,
  output logic [ADDRWIDTH-1:0] key_addr_r1,
  input  logic [KEY_W-1:0]     key_data_r1,
  output logic                 key_en_r2_n,
  output logic [ADDRWIDTH-1:0] key_addr_r2,
  input  logic [KEY_W-1:0]     key_data_r2,
  output logic                 val_en_r_n,
  output logic [ADDRWIDTH-1:0] val_addr_r,
  input  logic [VAL_W-1:0]     val_data_r
`ifdef RAM_LOOKUP_STATS_EN
  ,
  output logic [15:0]          hit_cnt,
  output logic [15:0]          miss_cnt
`endif
);
  localparam int AW = ADDRWIDTH;

  lookup_state_t  state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic [AW-1:0]  p_q, p_d;
  logic           pend_q, pend_d;
  logic           v2_q, v2_d;
  logic [AW-1:0]  base_q, base_d;
  logic           hit_q, hit_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic [AW-1:0]  addr_q, addr_d;

  logic [AW:0]    npairs, even_a, odd_a;
  logic [AW-1:0]  match_a;
  logic           cmp_v0, cmp_v1, cmp_hit, cmp_sel;

  assign cmp_v0 = (state_q == SCAN) && pend_q;
  assign cmp_v1 = cmp_v0 && v2_q;

  ram_lookup_pair_cmp #(.KEY_W(KEY_W)) u_cmp (
    .key_i (key_q),
    .d0_i  (key_data_r1),
    .d1_i  (key_data_r2),
    .v0_i  (cmp_v0),
    .v1_i  (cmp_v1),
    .hit_o (cmp_hit),
    .sel_o (cmp_sel)
  );

  assign npairs  = (cnt_q + {{AW{1'b0}}, 1'b1}) >> 1;
  assign even_a  = {p_q, 1'b0};
  assign odd_a   = {p_q, 1'b1};
  assign match_a = base_q | AW'(cmp_sel);

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_hit   = hit_q;
  assign resp_val   = val_q;
  assign resp_addr  = addr_q;

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    pend_d      = pend_q;
    v2_d        = v2_q;
    base_d      = base_q;
    hit_d       = hit_q;
    val_d       = val_q;
    addr_d      = addr_q;
    key_en_r1_n = 1'b1;
    key_addr_r1 = '0;
    key_en_r2_n = 1'b1;
    key_addr_r2 = '0;
    val_en_r_n  = 1'b1;
    val_addr_r  = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          key_d   = req_key;
          cnt_d   = req_count;
          p_d     = '0;
          pend_d  = 1'b0;
          v2_d    = 1'b0;
          hit_d   = 1'b0;
          val_d   = '0;
          addr_d  = '0;
          state_d = (req_count == '0) ? RESP : SCAN;
        end
      end
      SCAN: begin
        if (cmp_hit) begin
          val_en_r_n = 1'b0;
          val_addr_r = match_a;
          hit_d      = 1'b1;
          addr_d     = match_a;
          state_d    = VAL;
        end else if ({1'b0, p_q} < npairs) begin
          key_en_r1_n = 1'b0;
          key_addr_r1 = even_a[AW-1:0];
          // Odd slot past the table end is left unread and never compared.
          if (odd_a < cnt_q) begin
            key_en_r2_n = 1'b0;
            key_addr_r2 = odd_a[AW-1:0];
          end
          v2_d   = (odd_a < cnt_q);
          pend_d = 1'b1;
          base_d = even_a[AW-1:0];
          p_d    = p_q + 1'b1;
        end else begin
          // A miss also drains through VAL so the response slot is uniform.
          state_d = VAL;
        end
      end
      VAL: begin
        if (hit_q) val_d = val_data_r;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      pend_q  <= 1'b0;
      v2_q    <= 1'b0;
      base_q  <= '0;
      hit_q   <= 1'b0;
      val_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      pend_q  <= pend_d;
      v2_q    <= v2_d;
      base_q  <= base_d;
      hit_q   <= hit_d;
      val_q   <= val_d;
      addr_q  <= addr_d;
    end
  end

`ifdef RAM_LOOKUP_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  logic        resp_fire;

  assign resp_fire = resp_valid && resp_ready;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (resp_fire) begin
      if (hit_q && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (!hit_q && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ram_lookup.sv
// Directed bench for ram_lookup with behavioural mem0/mem1 read models.
module tb_ram_lookup;
  import ram_lookup_pkg::*;

  localparam int AW = 3;
  localparam int KW = 64;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [KW-1:0] req_key = '0;
  logic [AW:0]   req_count = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_hit;
  logic [VW-1:0] resp_val;
  logic [AW-1:0] resp_addr;
  logic          key_en_r1_n, key_en_r2_n, val_en_r_n;
  logic [AW-1:0] key_addr_r1, key_addr_r2, val_addr_r;
  logic [KW-1:0] key_data_r1 = '0, key_data_r2 = '0;
  logic [VW-1:0] val_data_r = '0;
`ifdef RAM_LOOKUP_STATS_EN
  logic [15:0]   hit_cnt, miss_cnt;
`endif

  char_t         mem0 [8];
  logic [VW-1:0] mem1 [8];

  int n_tests = 0;
  int n_fail  = 0;
  int a5_cnt  = 0;
  int en_cnt  = 0;

  always #5 clk = ~clk;

  ram_lookup #(.ADDRWIDTH(AW), .KEY_W(KW), .VAL_W(VW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_count(req_count),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_val(resp_val), .resp_addr(resp_addr),
    .key_en_r1_n(key_en_r1_n), .key_addr_r1(key_addr_r1), .key_data_r1(key_data_r1),
    .key_en_r2_n(key_en_r2_n), .key_addr_r2(key_addr_r2), .key_data_r2(key_data_r2),
    .val_en_r_n(val_en_r_n), .val_addr_r(val_addr_r), .val_data_r(val_data_r)
`ifdef RAM_LOOKUP_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // Synchronous-read RAM models: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (!key_en_r1_n) key_data_r1 <= mem0[key_addr_r1];
    if (!key_en_r2_n) key_data_r2 <= mem0[key_addr_r2];
    if (!val_en_r_n)  val_data_r  <= mem1[val_addr_r];
    if (!key_en_r2_n && key_addr_r2 == 3'd5) a5_cnt <= a5_cnt + 1;
    if (!key_en_r1_n || !key_en_r2_n || !val_en_r_n) en_cnt <= en_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input char_t key, input logic [AW:0] cnt, output int lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_key   = key;
    req_count = cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic check_resp(input string tag, input int lat, input int elat,
                            input logic hit, input logic [VW-1:0] val, input logic [AW-1:0] addr);
    check({tag, "_lat"},  64'(lat), 64'(elat));
    check({tag, "_hit"},  64'(resp_hit), 64'(hit));
    check({tag, "_val"},  64'(resp_val), 64'(val));
    check({tag, "_addr"}, 64'(resp_addr), 64'(addr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, a5_base, en_base, vcnt;
    logic          h_hit;
    logic [VW-1:0] h_val;
    logic [AW-1:0] h_addr;

    for (int i = 0; i < 8; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
    mem0[0] = "Nesrine";  mem1[0] = 8'hFF;
    mem0[1] = "Sridhar";  mem1[1] = 8'hAA;
    mem0[2] = "Yong";     mem1[2] = 8'hBB;
    mem0[3] = "Rupkatha"; mem1[3] = 8'hEE;
    mem0[4] = "Aart";     mem1[4] = 8'hCC;

    // Reset state
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_hit", 64'(resp_hit), 64'd0);
    check("rst_resp_val", 64'(resp_val), 64'd0);
    check("rst_resp_addr", 64'(resp_addr), 64'd0);
    check("rst_en1", 64'(key_en_r1_n), 64'd1);
    check("rst_en2", 64'(key_en_r2_n), 64'd1);
    check("rst_ven", 64'(val_en_r_n), 64'd1);
    check("rst_addrs", 64'({key_addr_r1, key_addr_r2, val_addr_r}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Hits in pairs 0, 1, 2
    lookup("Nesrine", 4'd5, lat);
    check_resp("nesrine", lat, 4, 1'b1, 8'hFF, 3'd0);
    take_resp();
    lookup("Rupkatha", 4'd5, lat);
    check_resp("rupkatha", lat, 5, 1'b1, 8'hEE, 3'd3);
    take_resp();
    a5_base = a5_cnt;
    lookup("Aart", 4'd5, lat);
    check_resp("aart", lat, 6, 1'b1, 8'hCC, 3'd4);
    take_resp();
    check("aart_no_addr5", 64'(a5_cnt - a5_base), 64'd0);

    // Misses
    lookup("Bob", 4'd5, lat);
    check_resp("bob5", lat, 6, 1'b0, 8'h00, 3'd0);
    take_resp();
    en_base = en_cnt;
    lookup("Bob", 4'd0, lat);
    check_resp("bob0", lat, 1, 1'b0, 8'h00, 3'd0);
    check("bob0_no_en", 64'(en_cnt - en_base), 64'd0);
    take_resp();

    // Duplicate key: even address wins
    mem0[3] = "Yong";
    lookup("Yong", 4'd5, lat);
    check_resp("dup_yong", lat, 5, 1'b1, 8'hBB, 3'd2);
    take_resp();
    mem0[3] = "Rupkatha";
    lookup("Aart", 4'd4, lat);
    check_resp("aart_cnt4", lat, 5, 1'b0, 8'h00, 3'd0);
    take_resp();

    // Backpressure: response held stable, no accept while stalled
    lookup("Sridhar", 4'd5, lat);
    check_resp("hold", lat, 4, 1'b1, 8'hAA, 3'd1);
    h_hit = resp_hit; h_val = resp_val; h_addr = resp_addr;
    req_valid = 1'b1; req_key = "Bob"; req_count = 4'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_stable", 64'({resp_hit, resp_val, resp_addr}), 64'({h_hit, h_val, h_addr}));
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    take_resp();
    @(negedge clk);
    check("post_hold_ready", 64'(req_ready), 64'd1);
    lookup("Yong", 4'd5, lat);
    check_resp("post_hold", lat, 5, 1'b1, 8'hBB, 3'd2);
    take_resp();

    // Reset mid-scan abandons the lookup
    @(negedge clk);
    req_valid = 1'b1; req_key = "Aart"; req_count = 4'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("scan_issuing", 64'(key_en_r1_n), 64'd0);
    rst = 1'b1;
    #1;
    check("midrst_en", 64'({key_en_r1_n, key_en_r2_n, val_en_r_n}), 64'b111);
    check("midrst_valid", 64'(resp_valid), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid) vcnt++;
    end
    check("midrst_no_resp", 64'(vcnt), 64'd0);

`ifdef RAM_LOOKUP_STATS_EN
    check("stats_init_hit", 64'(hit_cnt), 64'd0);
    check("stats_init_miss", 64'(miss_cnt), 64'd0);
    lookup("Nesrine", 4'd5, lat);  take_resp();
    lookup("Bob", 4'd5, lat);      take_resp();
    lookup("Yong", 4'd5, lat);     take_resp();
    lookup("Aart", 4'd5, lat);     take_resp();
    @(negedge clk);
    check("stats_hit", 64'(hit_cnt), 64'd3);
    check("stats_miss", 64'(miss_cnt), 64'd1);
    rst = 1'b1;
    #1;
    check("stats_rst_hit", 64'(hit_cnt), 64'd0);
    check("stats_rst_miss", 64'(miss_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
